// File: rtl/uart_rx_to_axis.sv
// UART receiver that deserialises the RX line into words and emits each one as a single-beat AXI-Stream transfer.
// Frame format matches the AXIS-to-UART transmitter so the two blocks loop back directly.
module uart_rx_to_axis #(
    parameter int CLK_FREQ      = 100,
    parameter int BIT_RATE      = 115200,
    parameter int BIT_PER_WORD  = 8,
    parameter int PARITY_BIT    = 0,
    parameter int STOP_BITS_NUM = 1
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    rx,
    output logic [BIT_PER_WORD-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [1:0]              m_axis_tuser,
    output logic                    overrun_err
);

    localparam int CYCLES = (CLK_FREQ * 1_000_000) / BIT_RATE;
    localparam int HALF   = CYCLES / 2;
    localparam int CNT_W  = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam int IDX_W  = $clog2(BIT_PER_WORD);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BIT_PER_WORD - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        bitIdx_q, bitIdx_d;
    logic [BIT_PER_WORD-1:0] shift_q, shift_d;
    logic                    parErr_q, parErr_d;
    logic                    frmErr_q, frmErr_d;
    logic                    rxMeta_q, rxSync_q;
    logic                    frameDone;
    logic                    parCalc;

    logic [BIT_PER_WORD-1:0] tdata_q;
    logic [1:0]              tuser_q;
    logic                    tvalid_q;
    logic                    overrun_q;

    // Synchroniser idles high so a reset never looks like a start bit.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            parErr_q <= 1'b0;
            frmErr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            parErr_q <= parErr_d;
            frmErr_q <= frmErr_d;
        end
    end

    assign parCalc = (^shift_q) ^ rxSync_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        parErr_d  = parErr_q;
        frmErr_d  = frmErr_q;
        frameDone = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxSync_q) begin
                    state_d  = START;
                    bitIdx_d = '0;
                    parErr_d = 1'b0;
                    frmErr_d = 1'b0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rxSync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                // Shifting in from the top leaves the first (LSB) bit at index 0 once the word is full.
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    shift_d  = {rxSync_q, shift_q[BIT_PER_WORD-1:1]};
                    bitIdx_d = bitIdx_q + IDX_W'(1);
                    if (bitIdx_q == IDX_LAST) begin
                        state_d = (PARITY_BIT != 0) ? PARITY : STOP1;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    parErr_d = (PARITY_BIT == 1) ? ~parCalc : parCalc;
                    state_d  = STOP1;
                end
            end
            STOP1: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rxSync_q) begin
                        frmErr_d = 1'b1;
                    end
                    if (STOP_BITS_NUM == 2) begin
                        state_d = STOP2;
                    end else begin
                        state_d   = IDLE;
                        frameDone = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rxSync_q) begin
                        frmErr_d = 1'b1;
                    end
                    state_d   = IDLE;
                    frameDone = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A finished word is dropped only when the held word is still stalled.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tdata_q   <= '0;
            tuser_q   <= '0;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (tvalid_q && m_axis_tready) begin
                tvalid_q <= 1'b0;
            end
            if (frameDone) begin
                if (tvalid_q && !m_axis_tready) begin
                    overrun_q <= 1'b1;
                end else begin
                    tdata_q  <= shift_q;
                    tuser_q  <= {frmErr_d, parErr_q};
                    tvalid_q <= 1'b1;
                end
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign overrun_err   = overrun_q;

endmodule
